btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 146 ++++++++++++++
 tb/tb_btn_conditioner.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - push-button and slide-switch synchronizer, debouncer and edge-event generator
module btn_conditioner #(
    parameter int NB_BTN    = 4,
    parameter int NB_SW     = 4,
    parameter int NB_DEB    = 20,
    parameter int DEB_LIMIT = 1000000
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic [NB_BTN-1:0] i_btn,
    input  logic [NB_SW-1:0]  i_sw,
    output logic [NB_BTN-1:0] o_btn_level,
    output logic [NB_BTN-1:0] o_btn_press,
    output logic [NB_BTN-1:0] o_btn_release,
    output logic [NB_BTN-1:0] o_btn_toggle,
    output logic [NB_SW-1:0]  o_sw,
    output logic              o_sw_change
);

    localparam int NB_CH = NB_BTN + NB_SW;
    localparam logic [NB_DEB-1:0] CNT_LAST = NB_DEB'(DEB_LIMIT - 1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } deb_state_t;

    // Channels [NB_BTN-1:0] are buttons, the upper NB_SW channels are switches.
    logic [NB_CH-1:0] sync1;
    logic [NB_CH-1:0] sync2;
    logic [NB_CH-1:0] level_q;
    logic [NB_CH-1:0] level_d;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {i_sw, i_btn};
            sync2 <= sync1;
        end
    end

    for (genvar g = 0; g < NB_CH; g++) begin : g_ch
        deb_state_t        state_q;
        deb_state_t        state_d;
        logic [NB_DEB-1:0] cnt_q;
        logic [NB_DEB-1:0] cnt_d;
        logic              lvl_q;
        logic              lvl_d;

        always_ff @(posedge clock or negedge i_reset) begin
            if (!i_reset) begin
                state_q <= STABLE_LOW;
                cnt_q   <= '0;
                lvl_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                lvl_q   <= lvl_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            lvl_d   = lvl_q;
            case (state_q)
                STABLE_LOW: begin
                    if (sync2[g]) begin
                        state_d = WAIT_HIGH;
                        cnt_d   = NB_DEB'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (!sync2[g]) begin
                        state_d = STABLE_LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = STABLE_HIGH;
                        cnt_d   = '0;
                        lvl_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + NB_DEB'(1);
                    end
                end
                STABLE_HIGH: begin
                    if (!sync2[g]) begin
                        state_d = WAIT_LOW;
                        cnt_d   = NB_DEB'(1);
                    end
                end
                WAIT_LOW: begin
                    if (sync2[g]) begin
                        state_d = STABLE_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = STABLE_LOW;
                        cnt_d   = '0;
                        lvl_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + NB_DEB'(1);
                    end
                end
                default: begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                    lvl_d   = 1'b0;
                end
            endcase
        end

        assign level_q[g] = lvl_q;
        assign level_d[g] = lvl_d;
    end

    // Events are registered on the same edge as the level, so a pulse lines up
    // with the first cycle the new level is visible.
    logic [NB_BTN-1:0] press_d;
    logic [NB_BTN-1:0] release_d;
    logic              sw_change_d;

    assign press_d     = level_d[NB_BTN-1:0] & ~level_q[NB_BTN-1:0];
    assign release_d   = ~level_d[NB_BTN-1:0] & level_q[NB_BTN-1:0];
    assign sw_change_d = |(level_d[NB_CH-1:NB_BTN] ^ level_q[NB_CH-1:NB_BTN]);

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            o_btn_press   <= '0;
            o_btn_release <= '0;
            o_btn_toggle  <= '0;
            o_sw_change   <= 1'b0;
        end else begin
            o_btn_press   <= press_d;
            o_btn_release <= release_d;
            o_btn_toggle  <= o_btn_toggle ^ press_d;
            o_sw_change   <= sw_change_d;
        end
    end

    assign o_btn_level = level_q[NB_BTN-1:0];
    assign o_sw        = level_q[NB_CH-1:NB_BTN];

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed self-checking bench for btn_conditioner
module tb_btn_conditioner;

    logic       clock = 1'b0;
    logic       i_reset;
    logic [3:0] i_btn;
    logic [3:0] i_sw;
    logic [3:0] o_btn_level;
    logic [3:0] o_btn_press;
    logic [3:0] o_btn_release;
    logic [3:0] o_btn_toggle;
    logic [3:0] o_sw;
    logic       o_sw_change;

    int passed = 0;
    int total  = 0;
    int npress;
    int nrel;
    int nchg;
    int ptick;
    int ctick;
    logic [3:0] pval;
    logic [3:0] rval;
    logic [8:0] bounce;
    logic [20:0] all_out;

    assign all_out = {o_btn_level, o_btn_press, o_btn_release, o_btn_toggle, o_sw, o_sw_change};

    btn_conditioner #(
        .NB_BTN   (4),
        .NB_SW    (4),
        .NB_DEB   (3),
        .DEB_LIMIT(4)
    ) dut (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_btn        (i_btn),
        .i_sw         (i_sw),
        .o_btn_level  (o_btn_level),
        .o_btn_press  (o_btn_press),
        .o_btn_release(o_btn_release),
        .o_btn_toggle (o_btn_toggle),
        .o_sw         (o_sw),
        .o_sw_change  (o_sw_change)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        i_reset = 1'b0;
        i_btn   = 4'b0000;
        i_sw    = 4'b0000;
        tick(3);
        chk("reset_outputs", 32'(all_out), 32'h0);
        i_reset = 1'b1;
        tick(8);
        chk("idle_outputs", 32'(all_out), 32'h0);

        // single clean press on button 0: level and press appear 5 edges after sampling
        i_btn = 4'b0001;
        tick(5);
        chk("press0_before", 32'({o_btn_level, o_btn_press}), 32'h00);
        tick(1);
        chk("press0_level_pulse", 32'({o_btn_level, o_btn_press, o_btn_toggle}), 32'h111);
        tick(1);
        chk("press0_pulse_end", 32'({o_btn_level, o_btn_press}), 32'h10);

        // 3-cycle glitch on button 1 must be ignored
        i_btn = 4'b0011;
        tick(3);
        i_btn = 4'b0001;
        for (int t = 0; t < 4; t++) begin
            tick(1);
            chk("glitch1_quiet", 32'({o_btn_level, o_btn_press, o_btn_release, o_btn_toggle}), 32'h1001);
        end
        tick(4);

        // release button 0; toggle unaffected
        i_btn = 4'b0000;
        tick(6);
        chk("release0", 32'({o_btn_level, o_btn_release, o_btn_toggle}), 32'h011);
        tick(1);
        chk("release0_end", 32'(o_btn_release), 32'h0);

        // bounce 1,0,1,1,0,1,1,1,1 then hold: one press, tick 10
        bounce = 9'b111101101;
        npress = 0;
        nrel   = 0;
        ptick  = -1;
        for (int t = 0; t < 20; t++) begin
            if (t < 9) i_btn[0] = bounce[t];
            else i_btn[0] = 1'b1;
            tick(1);
            if (o_btn_press[0]) begin
                npress++;
                ptick = t;
            end
            if (o_btn_release[0]) nrel++;
        end
        chk("bounce_press_count", 32'(npress), 32'd1);
        chk("bounce_press_tick", 32'(ptick), 32'd10);
        chk("bounce_no_release", 32'(nrel), 32'd0);
        chk("bounce_toggle_back", 32'({o_btn_level, o_btn_toggle}), 32'h10);
        i_btn = 4'b0000;
        tick(8);
        chk("bounce_released", 32'({o_btn_level, o_btn_toggle}), 32'h00);

        // switches 0000 -> 1010 in one step: single change pulse
        i_sw  = 4'b1010;
        nchg  = 0;
        ctick = -1;
        for (int t = 0; t < 10; t++) begin
            tick(1);
            if (o_sw_change) begin
                nchg++;
                ctick = t;
                chk("sw_at_pulse", 32'(o_sw), 32'ha);
            end
        end
        chk("sw_change_count", 32'(nchg), 32'd1);
        chk("sw_change_tick", 32'(ctick), 32'd5);
        chk("sw_value", 32'(o_sw), 32'ha);

        // button 2 held, reset asserted when counter reaches 2
        i_btn = 4'b0100;
        tick(4);
        i_reset = 1'b0;
        #1;
        chk("async_reset_clear", 32'(all_out), 32'h0);
        tick(2);
        chk("reset_held_clear", 32'(all_out), 32'h0);
        i_reset = 1'b1;
        npress = 0;
        nchg   = 0;
        ptick  = -1;
        for (int t = 0; t < 10; t++) begin
            tick(1);
            if (o_btn_press[2]) begin
                npress++;
                ptick = t;
            end
            if (o_sw_change) nchg++;
        end
        chk("post_reset_press_count", 32'(npress), 32'd1);
        chk("post_reset_press_tick", 32'(ptick), 32'd5);
        chk("post_reset_sw_change", 32'(nchg), 32'd1);
        chk("post_reset_state", 32'({o_btn_level, o_btn_toggle, o_sw}), 32'h44a);

        // all buttons together
        i_btn = 4'b0000;
        tick(8);
        i_btn  = 4'b1111;
        npress = 0;
        pval   = 4'b0000;
        for (int t = 0; t < 10; t++) begin
            tick(1);
            if (o_btn_press != 4'b0000) begin
                npress++;
                pval = o_btn_press;
            end
        end
        chk("all_press_cycles", 32'(npress), 32'd1);
        chk("all_press_value", 32'(pval), 32'hf);
        chk("all_press_toggle", 32'(o_btn_toggle), 32'hb);
        i_btn = 4'b0000;
        nrel  = 0;
        rval  = 4'b0000;
        for (int t = 0; t < 10; t++) begin
            tick(1);
            if (o_btn_release != 4'b0000) begin
                nrel++;
                rval = o_btn_release;
            end
        end
        chk("all_release_cycles", 32'(nrel), 32'd1);
        chk("all_release_value", 32'(rval), 32'hf);
        chk("all_release_state", 32'({o_btn_level, o_btn_toggle}), 32'h0b);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
